// File: rtl/vga_mem_arbiter_if.sv
// Bus bundle between the display fetcher, the CPU port and the video RAM,
// as seen by the video memory arbiter.
interface vga_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              vga_blank_n;
  logic              pix_req;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_ack;
  logic [DATA_W-1:0] pix_rdata;
  logic              pix_valid;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vga_blank_n, pix_req, pix_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output pix_ack, pix_rdata, pix_valid, cpu_ack, cpu_rdata, cpu_valid, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output vga_blank_n, pix_req, pix_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  pix_ack, pix_rdata, pix_valid, cpu_ack, cpu_rdata, cpu_valid, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Single-port video RAM arbiter: display fetches win during active video,
// the CPU wins during blanking or once it has been starved long enough.
module vga_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  vga_mem_arbiter_if.slave   bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, GNT_PIX, GNT_CPU} state_t;

  state_t            state, nxt_state;
  logic              run;
  logic [SW-1:0]     starve_cnt, nxt_starve;
  logic              pix_elig, cpu_elig;
  logic [ADDR_W-1:0] mem_addr_q, nxt_addr;
  logic              mem_we_q, nxt_we;
  logic [DATA_W-1:0] mem_wdata_q, nxt_wdata;
  logic              rd_pix_q, rd_cpu_q;
  logic              pix_valid_q, cpu_valid_q;
  logic [DATA_W-1:0] pix_rdata_q, cpu_rdata_q;

  // Decisions are held off until one full cycle out of reset has passed,
  // and a requester granted this cycle sits out this cycle's decision.
  always_comb begin
    nxt_state  = IDLE;
    nxt_addr   = mem_addr_q;
    nxt_we     = 1'b0;
    nxt_wdata  = mem_wdata_q;
    nxt_starve = starve_cnt;
    pix_elig   = run && bus.pix_req && (state != GNT_PIX);
    cpu_elig   = run && bus.cpu_req && (state != GNT_CPU);

    if (pix_elig && cpu_elig) begin
      if (!bus.vga_blank_n || (starve_cnt == SW'(STARVE_MAX)))
        nxt_state = GNT_CPU;
      else
        nxt_state = GNT_PIX;
    end else if (pix_elig) begin
      nxt_state = GNT_PIX;
    end else if (cpu_elig) begin
      nxt_state = GNT_CPU;
    end

    case (nxt_state)
      GNT_PIX: begin
        nxt_addr = bus.pix_addr;
      end
      GNT_CPU: begin
        nxt_addr  = bus.cpu_addr;
        nxt_we    = bus.cpu_we;
        nxt_wdata = bus.cpu_wdata;
      end
      default: ;
    endcase

    if (!bus.cpu_req || (nxt_state == GNT_CPU) || (state == GNT_CPU))
      nxt_starve = '0;
    else if (starve_cnt != SW'(STARVE_MAX))
      nxt_starve = starve_cnt + SW'(1);
  end

  // Grant register plus the RAM command it drives.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      run         <= 1'b0;
      starve_cnt  <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state       <= nxt_state;
      run         <= 1'b1;
      starve_cnt  <= nxt_starve;
      mem_addr_q  <= nxt_addr;
      mem_we_q    <= nxt_we;
      mem_wdata_q <= nxt_wdata;
    end
  end

  // Read return path: the tag follows the grant by one cycle to line up with
  // mem_rdata, then data is captured into the requester's output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_pix_q    <= 1'b0;
      rd_cpu_q    <= 1'b0;
      pix_valid_q <= 1'b0;
      cpu_valid_q <= 1'b0;
      pix_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      rd_pix_q    <= (state == GNT_PIX);
      rd_cpu_q    <= (state == GNT_CPU) && !mem_we_q;
      pix_valid_q <= rd_pix_q;
      cpu_valid_q <= rd_cpu_q;
      if (rd_pix_q)
        pix_rdata_q <= bus.mem_rdata;
      if (rd_cpu_q)
        cpu_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.pix_ack   = (state == GNT_PIX);
  assign bus.cpu_ack   = (state == GNT_CPU);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.cpu_valid = cpu_valid_q;
  assign bus.pix_rdata = pix_rdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: a behavioural video RAM, a scoreboard of expected
// read returns keyed by requester, and one task per scenario.
module tb_vga_mem_arbiter;

  localparam int STARVE_MAX = 8;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  logic mon_en;
  logic [15:0] last_gnt_addr;
  logic [15:0] ram     [0:1023];
  logic [15:0] ref_mem [0:1023];
  exp_t pix_q[$];
  exp_t cpu_q[$];

  vga_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  vga_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1)
      ram[bus.mem_addr[9:0]] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr[9:0]];
  end

  // Scoreboard: grants push expected returns, valid strobes pop and compare.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      cyc++;
      checks++;
      if (bus.pix_ack && bus.cpu_ack) begin
        errors++;
        $display("[TB] FAIL double_grant: pix_ack=%b cpu_ack=%b, required at most one", bus.pix_ack, bus.cpu_ack);
      end
      if (bus.pix_ack) begin
        checks++;
        if ({bus.mem_we, bus.mem_addr} !== {1'b0, bus.pix_addr}) begin
          errors++;
          $display("[TB] FAIL pix_cmd: we/addr=%b/%h, required 0/%h", bus.mem_we, bus.mem_addr, bus.pix_addr);
        end
        e.data = ref_mem[bus.pix_addr[9:0]];
        e.due  = cyc + 2;
        pix_q.push_back(e);
        last_gnt_addr = bus.pix_addr;
      end
      if (bus.cpu_ack) begin
        checks++;
        if ({bus.mem_we, bus.mem_addr} !== {bus.cpu_we, bus.cpu_addr}) begin
          errors++;
          $display("[TB] FAIL cpu_cmd: we/addr=%b/%h, required %b/%h", bus.mem_we, bus.mem_addr, bus.cpu_we, bus.cpu_addr);
        end
        if (bus.cpu_we) begin
          checks++;
          if (bus.mem_wdata !== bus.cpu_wdata) begin
            errors++;
            $display("[TB] FAIL cpu_wdata: got %h, required %h", bus.mem_wdata, bus.cpu_wdata);
          end
          ref_mem[bus.cpu_addr[9:0]] = bus.cpu_wdata;
        end else begin
          e.data = ref_mem[bus.cpu_addr[9:0]];
          e.due  = cyc + 2;
          cpu_q.push_back(e);
        end
        last_gnt_addr = bus.cpu_addr;
      end
      if (bus.pix_valid) begin
        checks++;
        if (pix_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL pix_unexpected: pix_valid=1 at cycle %0d, required 0", cyc);
        end else begin
          e = pix_q.pop_front();
          if (bus.pix_rdata !== e.data || cyc != e.due) begin
            errors++;
            $display("[TB] FAIL pix_return: data=%h cycle=%0d, required %h cycle=%0d", bus.pix_rdata, cyc, e.data, e.due);
          end
        end
      end else if (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL pix_missing: pix_valid=0 at cycle %0d, required 1", cyc);
        void'(pix_q.pop_front());
      end
      if (bus.cpu_valid) begin
        checks++;
        if (cpu_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL cpu_unexpected: cpu_valid=1 at cycle %0d, required 0", cyc);
        end else begin
          e = cpu_q.pop_front();
          if (bus.cpu_rdata !== e.data || cyc != e.due) begin
            errors++;
            $display("[TB] FAIL cpu_return: data=%h cycle=%0d, required %h cycle=%0d", bus.cpu_rdata, cyc, e.data, e.due);
          end
        end
      end else if (cpu_q.size() > 0 && cpu_q[0].due <= cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL cpu_missing: cpu_valid=0 at cycle %0d, required 1", cyc);
        void'(cpu_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.pix_req = 1'b1;
    bus.pix_addr = 16'h0100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.pix_ack, bus.cpu_ack, bus.mem_we, bus.pix_valid, bus.cpu_valid} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: ack/we/valid=%b, required 00000",
               {bus.pix_ack, bus.cpu_ack, bus.mem_we, bus.pix_valid, bus.cpu_valid});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.pix_rdata, bus.cpu_rdata} !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: addr/wdata/prdata/crdata=%h/%h/%h/%h, required all 0",
               bus.mem_addr, bus.mem_wdata, bus.pix_rdata, bus.cpu_rdata);
    end
    tick();
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.pix_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_grant_early: pix_ack=%b, required 0", bus.pix_ack);
    end
    @(negedge clk);
    checks++;
    if (bus.pix_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_grant: pix_ack=%b, required 1", bus.pix_ack);
    end
    tick();
    bus.pix_req = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_pix_stream();
    bus.vga_blank_n = 1'b1;
    bus.pix_addr = 16'h0100;
    bus.pix_req = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.pix_ack !== ((i % 2) == 1)) begin
        errors++;
        $display("[TB] FAIL pix_stream[%0d]: pix_ack=%b, required %b", i, bus.pix_ack, (i % 2) == 1);
      end
    end
    tick();
    bus.pix_req = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_cpu_write_blank();
    bus.vga_blank_n = 1'b0;
    bus.pix_addr = 16'h0100;
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 16'h0042;
    bus.cpu_wdata = 16'h1234;
    bus.pix_req = 1'b1;
    bus.cpu_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.cpu_ack, bus.pix_ack, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {3'b101, 16'h0042, 16'h1234}) begin
      errors++;
      $display("[TB] FAIL blank_cpu_first: cack/pack/we/addr/wdata=%b%b%b/%h/%h, required 101/0042/1234",
               bus.cpu_ack, bus.pix_ack, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.cpu_ack, bus.pix_ack, bus.mem_we, bus.mem_addr} !== {3'b010, 16'h0100}) begin
      errors++;
      $display("[TB] FAIL blank_pix_next: cack/pack/we/addr=%b%b%b/%h, required 010/0100",
               bus.cpu_ack, bus.pix_ack, bus.mem_we, bus.mem_addr);
    end
    tick();
    bus.pix_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.cpu_ack, bus.pix_ack, bus.mem_we, bus.mem_addr} !== {3'b000, 16'h0100}) begin
      errors++;
      $display("[TB] FAIL blank_idle_after: cack/pack/we/addr=%b%b%b/%h, required 000/0100",
               bus.cpu_ack, bus.pix_ack, bus.mem_we, bus.mem_addr);
    end
    repeat (4) tick();
  endtask

  task automatic test_starve();
    logic got;
    int   n;
    got = 1'b0;
    n = 0;
    bus.vga_blank_n = 1'b1;
    bus.pix_addr = 16'h0100;
    bus.pix_req = 1'b1;
    repeat (3) tick();
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 16'h0042;
    bus.cpu_req = 1'b1;
    for (int i = 1; i <= STARVE_MAX + 2; i++) begin
      @(negedge clk);
      if (!got && bus.cpu_ack) begin
        got = 1'b1;
        n = i;
      end
      if (got) break;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL starve_bound: no cpu_ack within %0d cycles, required cpu_ack", STARVE_MAX + 2);
    end else begin
      $display("[TB] cpu_ack after %0d cycles of holding", n);
    end
    tick();
    bus.cpu_req = 1'b0;
    repeat (2) tick();
    bus.pix_req = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_alternate();
    bus.vga_blank_n = 1'b1;
    bus.pix_addr = 16'h0100;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 16'h0042;
    bus.pix_req = 1'b1;
    bus.cpu_req = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.pix_ack, bus.cpu_ack} !== {(i % 2) == 0, (i % 2) == 1}) begin
        errors++;
        $display("[TB] FAIL alternate[%0d]: pix_ack/cpu_ack=%b%b, required %b%b",
                 i, bus.pix_ack, bus.cpu_ack, (i % 2) == 0, (i % 2) == 1);
      end
    end
    bus.pix_req = 1'b0;
    bus.cpu_req = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.pix_ack, bus.cpu_ack, bus.mem_we, bus.mem_addr} !== {3'b000, last_gnt_addr}) begin
        errors++;
        $display("[TB] FAIL idle_hold[%0d]: ack/we/addr=%b%b%b/%h, required 000/%h",
                 i, bus.pix_ack, bus.cpu_ack, bus.mem_we, bus.mem_addr, last_gnt_addr);
      end
    end
    checks++;
    if (pix_q.size() != 0 || cpu_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: pending pix=%0d cpu=%0d, required 0/0", pix_q.size(), cpu_q.size());
    end
  endtask

  task automatic test_reset_flush();
    logic got;
    logic seen;
    got = 1'b0;
    seen = 1'b0;
    tick();
    bus.pix_addr = 16'h0100;
    bus.pix_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.pix_ack) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL flush_ack: pix_ack never seen, required 1");
    end
    tick();
    rst = 1'b0;
    bus.pix_req = 1'b0;
    mon_en = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({bus.pix_ack, bus.cpu_ack, bus.mem_we, bus.pix_valid, bus.cpu_valid,
         bus.mem_addr, bus.mem_wdata, bus.pix_rdata, bus.cpu_rdata} !== 69'h0) begin
      errors++;
      $display("[TB] FAIL flush_zero: ack/we/valid=%b%b%b%b%b addr/wdata/prdata/crdata=%h/%h/%h/%h, required all 0",
               bus.pix_ack, bus.cpu_ack, bus.mem_we, bus.pix_valid, bus.cpu_valid,
               bus.mem_addr, bus.mem_wdata, bus.pix_rdata, bus.cpu_rdata);
    end
    tick();
    rst = 1'b1;
    pix_q.delete();
    cpu_q.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.pix_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL flush_valid: pix_valid=1 after reset, required 0");
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    mon_en = 1'b0;
    last_gnt_addr = '0;
    rst = 1'b0;
    bus.vga_blank_n = 1'b1;
    bus.pix_req = 1'b0;
    bus.pix_addr = '0;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 16'(i * 37 + 5);
      ref_mem[i] = 16'(i * 37 + 5);
    end
    ram[256] = 16'hABCD;
    ref_mem[256] = 16'hABCD;

    test_reset();
    test_pix_stream();
    test_cpu_write_blank();
    test_starve();
    test_alternate();
    test_idle();
    test_reset_flush();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_mem_arbiter.md
VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, video memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, video memory data width.
REQ-003 The block SHALL have parameter STARVE_MAX, default 8, maximum consecutive cycles a pending CPU request may lose arbitration.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 vga_blank_n  input  1  1 = display in active video, 0 = blanking.
REQ-007 pix_req  input  1  display pixel-fetch request, held until pix_ack.
REQ-008 pix_addr  input  ADDR_W  pixel-fetch address, stable while pix_req=1.
REQ-009 pix_ack  output  1  one-cycle grant pulse to display.
REQ-010 pix_rdata  output  DATA_W  pixel read data.
REQ-011 pix_valid  output  1  one-cycle strobe qualifying pix_rdata.
REQ-012 cpu_req  input  1  CPU access request, held until cpu_ack.
REQ-013 cpu_we  input  1  1 = write, 0 = read; stable while cpu_req=1.
REQ-014 cpu_addr  input  ADDR_W  CPU access address.
REQ-015 cpu_wdata  input  DATA_W  CPU write data.
REQ-016 cpu_ack  output  1  one-cycle grant pulse to CPU.
REQ-017 cpu_rdata  output  DATA_W  CPU read data.
REQ-018 cpu_valid  output  1  one-cycle strobe qualifying cpu_rdata (reads only).
REQ-019 mem_addr  output  ADDR_W  address to single-port synchronous video RAM.
REQ-020 mem_we  output  1  RAM write enable.
REQ-021 mem_wdata  output  DATA_W  RAM write data.
REQ-022 mem_rdata  input  DATA_W  RAM read data, valid the cycle after mem_addr presented with mem_we=0.

Function
REQ-023 FSM states SHALL be IDLE, GNT_PIX, GNT_CPU; state = grant issued in the current cycle; pix_ack=1 only in GNT_PIX, cpu_ack=1 only in GNT_CPU.
REQ-024 Decision in cycle N SHALL set state, ack, mem_addr, mem_we, mem_wdata registered for cycle N+1.
REQ-025 A requester acked in cycle N SHALL be ineligible for the decision made in cycle N (no double grant of a held request).
REQ-026 Eligible pix_req only -> GNT_PIX; eligible cpu_req only -> GNT_CPU; neither -> IDLE.
REQ-027 Both eligible, vga_blank_n=0 -> GNT_CPU.
REQ-028 Both eligible, vga_blank_n=1 -> GNT_PIX unless starve_cnt == STARVE_MAX, then GNT_CPU.
REQ-029 starve_cnt SHALL increment (saturating at STARVE_MAX) each cycle cpu_req=1 and CPU is not granted, and clear on CPU grant or cpu_req=0.
REQ-030 GNT_PIX: mem_addr=pix_addr, mem_we=0.
REQ-031 GNT_CPU: mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata; mem_we high exactly one cycle per write grant.
REQ-032 IDLE: mem_we=0; mem_addr, mem_wdata hold previous values.
REQ-033 Read latency: ack in cycle N+1 -> mem_rdata sampled in N+2 -> pix_rdata/pix_valid or cpu_rdata/cpu_valid asserted in N+3 for one cycle.
REQ-034 pix_rdata/cpu_rdata SHALL hold last value when respective valid=0.
REQ-035 Read pipeline SHALL carry requester tag; pix and cpu returns never swap, may occur on consecutive cycles.
REQ-036 CPU write SHALL produce no cpu_valid.
REQ-037 Throughput: any single requester SHALL be granted at most every second cycle; alternating grants SHALL sustain one grant per cycle.

Reset
REQ-038 rst=0 at a rising edge SHALL set state=IDLE, pix_ack=cpu_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, pix_valid=cpu_valid=0, pix_rdata=cpu_rdata=0, starve_cnt=0.
REQ-039 Reset mid-read SHALL flush in-flight reads; no valid strobe for them after rst returns high.
REQ-040 First grant SHALL occur no earlier than the cycle after the first edge with rst=1.

Verification
REQ-041 vga_blank_n=1, pix_req held, pix_addr=0x0100, mem_rdata=0xABCD -> pix_ack pulses on every second cycle, pix_valid with pix_rdata=0xABCD 2 cycles after each ack.
REQ-042 vga_blank_n=0, both held, cpu_we=1, cpu_addr=0x0042, cpu_wdata=0x1234 -> cpu_ack first, mem_we=1, mem_addr=0x0042, mem_wdata=0x1234 for one cycle, pix_ack next cycle.
REQ-043 vga_blank_n=1, pix_req permanently re-presented, cpu_req read held -> cpu_ack no later than STARVE_MAX=8 lost cycles after cpu_req rises; cpu_valid 2 cycles after cpu_ack.
REQ-044 Alternating pix read and cpu read -> grants every cycle, pix_valid and cpu_valid on consecutive cycles with correct data per tag.
REQ-045 rst=0 one cycle after a pix_ack -> no pix_valid afterwards; all outputs 0 per REQ-038.
REQ-046 No requests -> state IDLE, mem_we=0, mem_addr held.
